// File: rtl/axilite_timer_s.sv
// axilite_timer_s
//   AXI4-Lite slave exposing a programmable down-counter timer with a level
//   interrupt. Four 32-bit registers decoded on addr[3:2]:
//     0x00 CTRL   (RW) bit0 enable, bit1 auto_reload, bit2 irq_en
//     0x04 LOAD   (RW) reload value; a write also loads COUNT
//     0x08 COUNT  (RO) current count; writes accepted and ignored
//     0x0C STATUS (W1C) bit0 expired
//   Addresses with addr[ADDR_WIDTH-1:4] != 0 answer SLVERR (reads return 0).
//
// Ports
//   s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data, response channels
//   s_axi_ar* / s_axi_r*            : read address and data channels
//   irq                              : STATUS.expired & CTRL.irq_en
module axilite_timer_s #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic        ctrl_enable;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        expired_q;

    logic        wr_fire;
    logic        wr_in_range;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        rd_in_range;
    logic [31:0] rd_mux;
    logic        expire_evt;

    // Address bits [1:0] carry no information for full-word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                // Address and data must both be present before anything is accepted.
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_next = W_ACK;
                end
            end
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                w_next        = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign wr_fire     = (w_state == W_ACK);
    assign wr_in_range = (s_axi_awaddr[ADDR_WIDTH-1:4] == '0);
    assign wr_ctrl     = wr_fire && wr_in_range && (s_axi_awaddr[3:2] == 2'd0);
    assign wr_load     = wr_fire && wr_in_range && (s_axi_awaddr[3:2] == 2'd1);
    assign wr_status   = wr_fire && wr_in_range && (s_axi_awaddr[3:2] == 2'd3);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_bresp <= RESP_OKAY;
        end else if (wr_fire) begin
            s_axi_bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ------------------------------------------------------------------
    // Timer registers
    // ------------------------------------------------------------------
    assign expire_evt = ctrl_enable && (count_q == 32'd1);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            load_q           <= RESET_LOAD;
            count_q          <= RESET_LOAD;
            expired_q        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable      <= s_axi_wdata[0];
                ctrl_auto_reload <= s_axi_wdata[1];
                ctrl_irq_en      <= s_axi_wdata[2];
            end

            // A LOAD write overrides both decrement and reload.
            if (wr_load) begin
                load_q  <= s_axi_wdata;
                count_q <= s_axi_wdata;
            end else if (ctrl_enable) begin
                if (count_q > 32'd1) begin
                    count_q <= count_q - 32'd1;
                end else if (count_q == 32'd1) begin
                    count_q <= ctrl_auto_reload ? load_q : '0;
                end
            end

            // Expiry wins over a simultaneous W1C so no event is lost.
            if (expire_evt) begin
                expired_q <= 1'b1;
            end else if (wr_status && s_axi_wdata[0]) begin
                expired_q <= 1'b0;
            end
        end
    end

    assign irq = expired_q && ctrl_irq_en;

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_next = R_ACK;
                end
            end
            R_ACK: begin
                s_axi_arready = 1'b1;
                r_next        = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign rd_in_range = (s_axi_araddr[ADDR_WIDTH-1:4] == '0);

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[3:2])
            2'd0:    rd_mux = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_enable};
            2'd1:    rd_mux = load_q;
            2'd2:    rd_mux = count_q;
            default: rd_mux = {31'd0, expired_q};
        endcase
    end

    // Captured from pre-edge register values, so a read colliding with a
    // write to the same register observes the old contents.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (r_state == R_ACK) begin
            s_axi_rdata <= rd_in_range ? rd_mux : '0;
            s_axi_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: doc/axilite_timer_s.md
# axilite_timer_s

AXI4-Lite slave implementing a programmable down-counter timer with interrupt. It sits directly downstream of the `axilite_m` master as a second peripheral on the same bus, alongside the LED slave. It exposes four 32-bit registers (control, load, count, status) and drives a level interrupt when the counter expires.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, width of `s_axi_awaddr` / `s_axi_araddr`.
- `RESET_LOAD`, 32'h0000_0000, reset value of LOAD and COUNT.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `s_axi_aclk` input 1 — single clock.
- `s_axi_aresetn` input 1 — asynchronous, active-low reset.
- `s_axi_awvalid` input 1 — write address valid.
- `s_axi_awready` output 1 — write address ready.
- `s_axi_awaddr` input ADDR_WIDTH — write byte address.
- `s_axi_wvalid` input 1 — write data valid.
- `s_axi_wready` output 1 — write data ready.
- `s_axi_wdata` input 32 — write data; full-word writes only, no strobes.
- `s_axi_bvalid` output 1 — write response valid.
- `s_axi_bready` input 1 — write response ready.
- `s_axi_bresp` output 2 — 2'b00 OKAY, 2'b10 SLVERR.
- `s_axi_arvalid` input 1 — read address valid.
- `s_axi_arready` output 1 — read address ready.
- `s_axi_araddr` input ADDR_WIDTH — read byte address.
- `s_axi_rvalid` output 1 — read data valid.
- `s_axi_rready` input 1 — read data ready.
- `s_axi_rdata` output 32 — read data.
- `s_axi_rresp` output 2 — read response code.
- `irq` output 1 — `STATUS.expired & CTRL.irq_en`.

## Operation

Register map. Decode uses addr[3:2]. Any address with addr[ADDR_WIDTH-1:4] != 0 is out of range.
- 0x00 CTRL (RW): bit0 `enable`, bit1 `auto_reload`, bit2 `irq_en`. Bits [31:3] read 0.
- 0x04 LOAD (RW): reload value. A write also loads COUNT with the same value in the same cycle.
- 0x08 COUNT (RO): current count. Writes are accepted with OKAY and have no effect.
- 0x0C STATUS: bit0 `expired`. Writing 1 to bit0 clears it (W1C); writing 0 has no effect.
- Out-of-range address: write is ignored, response SLVERR; read returns 0, response SLVERR.

Counter update, each cycle with `enable` = 1:
- COUNT > 1: COUNT decrements by 1.
- COUNT == 1: COUNT becomes LOAD if `auto_reload`, else 0. `expired` is set.
- COUNT == 0: COUNT holds. No event.
- With `enable` = 0, COUNT holds.

Collisions in the same cycle:
- A LOAD write takes priority over decrement or reload.
- An expire event takes priority over a W1C clear, so `expired` stays 1.

Write FSM states:
- W_IDLE: when `awvalid & wvalid` are both high, go to W_ACK. A lone valid waits and is not accepted.
- W_ACK: `awready = wready = 1` for exactly one cycle. The register write is performed on this edge. Go to W_RESP.
- W_RESP: `bvalid = 1`, `bresp` held stable until `bready`. Return to W_IDLE on `bvalid & bready`.

Read FSM states:
- R_IDLE: `arvalid` goes to R_ACK.
- R_ACK: `arready = 1` for one cycle. `rdata`/`rresp` are captured on this edge. Go to R_DATA.
- R_DATA: `rvalid = 1`, `rdata` held until `rready`. Return to R_IDLE.

The read and write FSMs are independent. A read in the same cycle as a write to the same register returns the pre-write value.

## Timing

- Reset (asynchronous assert): all ready/valid outputs 0, `bresp`/`rresp` 2'b00, `rdata` 0, CTRL 0, LOAD and COUNT `RESET_LOAD`, `expired` 0, `irq` 0. Both FSMs return to idle.
- Reset asserted mid-transaction aborts it. No response is issued after deassert.
- Write latency: valids seen at edge k, ready high during cycle k+1, `bvalid` high from cycle k+2. Minimum 3 cycles per write with `bready` tied high.
- Read latency: `arvalid` at edge k, `arready` in cycle k+1, `rvalid` from cycle k+2.
- Backpressure: no new transaction of a given type is accepted while its response is pending.
- `irq` is a registered-state function with no combinational path from bus inputs. It asserts the cycle after `expired` sets with `irq_en` = 1.
- Timer expiry period with `auto_reload` = 1 is LOAD cycles. COUNT cycles LOAD, …, 1, LOAD.

## Test plan

- Reset, then read all four registers → 0, 0, 0, 0, all with OKAY.
- Write CTRL=0x1 and LOAD=5, leave `bready` high → COUNT reads 4,3,…; `expired`=1 exactly 5 cycles after the LOAD write; COUNT stays 0; `irq`=0 because `irq_en`=0.
- Write CTRL=0x7 and LOAD=3 → COUNT sequence 3,2,1,3,2,1; `irq` rises 1 cycle after the first expiry. Write STATUS=1 → `irq` drops. Time the clear to the expire cycle → `expired` stays 1.
- Raise `awvalid` 4 cycles before `wvalid` → no `awready` until both are high; a single handshake follows.
- Write to 0x10 and read from 0x20 → `bresp`=2'b10, `rresp`=2'b10, `rdata`=0, no register change.
- Hold `bready`/`rready` low for 6 cycles → `bvalid`/`rvalid`/data stable. A second `awvalid`/`wvalid` is not accepted. Assert reset mid-W_RESP → `bvalid`=0 immediately.
